// File: rtl/fc_layer_gen_stream_if.sv
// rtl/fc_layer_gen_stream_if.sv - input, weight and output streams of the fully-connected layer
interface fc_layer_gen_stream_if #(
    parameter int T = 8
);
    logic                input_valid;
    logic                input_ready;
    logic signed [T-1:0] input_data;
    logic                w_valid;
    logic                w_ready;
    logic signed [T-1:0] w_data;
    logic                output_valid;
    logic                output_ready;
    logic signed [T-1:0] output_data;

    modport slave (
        input  input_valid, input_data, w_valid, w_data, output_ready,
        output input_ready, w_ready, output_valid, output_data
    );

    modport master (
        output input_valid, input_data, w_valid, w_data, output_ready,
        input  input_ready, w_ready, output_valid, output_data
    );
endinterface

// File: rtl/fc_layer_gen_stream.sv
// rtl/fc_layer_gen_stream.sv - y = sat(W*x) over P MAC lanes with loadable weights (FC_RELU_EN: ReLU after sat)
module fc_layer_gen_stream #(
    parameter int M = 16,
    parameter int N = 8,
    parameter int T = 8,
    parameter int P = 4
) (
    input logic clk,
    input logic reset,
    fc_layer_gen_stream_if.slave bus
);
    localparam int ACC_W = 2 * T + $clog2(N);
    localparam int G     = M / P;
    localparam int LD    = G * N;
    localparam int AW    = (LD > 1) ? $clog2(LD) : 1;
    localparam int XW    = $clog2(N);
    localparam int NW    = $clog2(N + 1);
    localparam int PW    = (P > 1) ? $clog2(P) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;

    localparam logic [XW-1:0] X_LAST    = XW'(N - 1);
    localparam logic [NW-1:0] N_END     = NW'(N);
    localparam logic [PW-1:0] P_LAST    = PW'(P - 1);
    localparam logic [GW-1:0] G_LAST    = GW'(G - 1);
    localparam logic [AW-1:0] BASE_LAST = AW'((G - 1) * N);
    localparam logic [AW-1:0] N_STEP    = AW'(N);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (T - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (T - 1)));

    typedef enum logic [1:0] {IDLE, LOAD_X, MAC, OUT} state_t;

    state_t                  state;
    logic [XW-1:0]           xi;
    logic [NW-1:0]           n;
    logic [GW-1:0]           g;
    logic [PW-1:0]           j;
    logic [XW-1:0]           w_n;
    logic [PW-1:0]           w_lane;
    logic [AW-1:0]           w_base;
    logic signed [ACC_W-1:0] acc      [P];
    logic signed [ACC_W-1:0] acc_next [P];
    logic signed [2*T-1:0]   prod     [P];
    logic signed [T-1:0]     out_reg  [P];
    logic signed [T-1:0]     rd       [P];
    logic signed [T-1:0]     x_rd;
    logic signed [T-1:0]     x_mem    [N];
    logic signed [T-1:0]     w_mem    [P][LD];

    logic          x_we, w_we;
    logic [XW-1:0] x_waddr;
    logic [NW-1:0] n_rd;
    logic [AW-1:0] raddr;
    logic [AW-1:0] w_addr;

    assign bus.input_ready = (state == IDLE) || (state == LOAD_X);
    assign bus.w_ready     = (state == IDLE) && !bus.input_valid;
    assign x_we    = bus.input_valid && bus.input_ready;
    assign w_we    = bus.w_valid && bus.w_ready;
    assign x_waddr = (state == IDLE) ? '0 : xi;
    assign n_rd    = (n == N_END) ? '0 : n;
    assign raddr   = AW'(32'(g) * N + 32'(n_rd));
    assign w_addr  = w_base + AW'(w_n);

    function automatic logic signed [T-1:0] fin(input logic signed [ACC_W-1:0] a);
        logic signed [T-1:0] s;
        if (a > SAT_HI)
            s = SAT_HI[T-1:0];
        else if (a < SAT_LO)
            s = SAT_LO[T-1:0];
        else
            s = a[T-1:0];
`ifdef FC_RELU_EN
        if (s < 0)
            s = '0;
`endif
        return s;
    endfunction

    always_comb begin
        for (int k = 0; k < P; k++) begin
            prod[k]     = (2 * T)'(rd[k]) * (2 * T)'(x_rd);
            acc_next[k] = acc[k] + ACC_W'(prod[k]);
        end
    end

    // Storage is deliberately outside reset so weights survive a reset.
    always_ff @(posedge clk) begin
        if (x_we)
            x_mem[x_waddr] <= bus.input_data;
        if (w_we)
            w_mem[w_lane][w_addr] <= bus.w_data;
        x_rd <= x_mem[XW'(n_rd)];
        for (int k = 0; k < P; k++)
            rd[k] <= w_mem[k][raddr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            xi               <= '0;
            n                <= '0;
            g                <= '0;
            j                <= '0;
            w_n              <= '0;
            w_lane           <= '0;
            w_base           <= '0;
            bus.output_valid <= 1'b0;
            bus.output_data  <= '0;
            for (int k = 0; k < P; k++) begin
                acc[k]     <= '0;
                out_reg[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (x_we) begin
                        xi    <= XW'(1);
                        state <= LOAD_X;
                    end else if (w_we) begin
                        if (w_n == X_LAST) begin
                            w_n <= '0;
                            if (w_lane == P_LAST) begin
                                w_lane <= '0;
                                w_base <= (w_base == BASE_LAST) ? '0 : w_base + N_STEP;
                            end else begin
                                w_lane <= w_lane + PW'(1);
                            end
                        end else begin
                            w_n <= w_n + XW'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (x_we) begin
                        if (xi == X_LAST) begin
                            state <= MAC;
                            n     <= '0;
                            g     <= '0;
                            for (int k = 0; k < P; k++)
                                acc[k] <= '0;
                        end else begin
                            xi <= xi + XW'(1);
                        end
                    end
                end
                MAC: begin
                    // Read data lags the address by one cycle, so n==0 only issues a read.
                    if (n != '0)
                        for (int k = 0; k < P; k++)
                            acc[k] <= acc_next[k];
                    if (n == N_END) begin
                        for (int k = 0; k < P; k++)
                            out_reg[k] <= fin(acc_next[k]);
                        bus.output_data  <= fin(acc_next[0]);
                        bus.output_valid <= 1'b1;
                        j                <= '0;
                        state            <= OUT;
                    end else begin
                        n <= n + NW'(1);
                    end
                end
                OUT: begin
                    if (bus.output_ready) begin
                        if (j == P_LAST) begin
                            bus.output_valid <= 1'b0;
                            n                <= '0;
                            for (int k = 0; k < P; k++)
                                acc[k] <= '0;
                            if (g == G_LAST) begin
                                state <= IDLE;
                            end else begin
                                g     <= g + GW'(1);
                                state <= MAC;
                            end
                        end else begin
                            j               <= j + PW'(1);
                            bus.output_data <= out_reg[j + PW'(1)];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_gen_stream.sv
// tb/tb_fc_layer_gen_stream.sv - randomized self-checking bench for fc_layer_gen_stream
module tb_fc_layer_gen_stream;
    localparam int M = 16;
    localparam int N = 8;
    localparam int T = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    int W [M][N];
    int xv [N];
    int y [M];

    fc_layer_gen_stream_if #(.T(T)) bus ();

    fc_layer_gen_stream #(.M(M), .N(N), .T(T), .P(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int a);
        int r;
        r = a;
        if (r > (2 ** (T - 1)) - 1) r = (2 ** (T - 1)) - 1;
        if (r < -(2 ** (T - 1))) r = -(2 ** (T - 1));
`ifdef FC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic compute();
        for (int m = 0; m < M; m++) begin
            int s = 0;
            for (int k = 0; k < N; k++)
                s += W[m][k] * xv[k];
            y[m] = sat(s);
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic send_w(input int v);
        bus.w_valid = 1'b1;
        bus.w_data  = T'(v);
        #1;
        for (int t = 0; !bus.w_ready; t++) begin
            if (t > 50) begin
                check("w_ready_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++)
                send_w(W[m][k]);
    endtask

    task automatic send_x(output int h);
        h = 0;
        for (int i = 0; i < N; i++) begin
            bus.input_valid = 1'b1;
            bus.input_data  = T'(xv[i]);
            #1;
            for (int t = 0; !bus.input_ready; t++) begin
                if (t > 200) begin
                    check("input_ready_timeout", 0, 1);
                    break;
                end
                @(negedge clk);
                #1;
            end
            h = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        bus.input_valid = 1'b0;
    endtask

    task automatic collect(input int stall_at, input bit rnd, input int n_out, output int first_v);
        first_v = -1;
        for (int i = 0; i < n_out; i++) begin
            bit got = 1'b0;
            int t = 0;
            if (i == stall_at) begin
                bus.output_ready = 1'b0;
                #1;
                while (!bus.output_valid && t < 100) begin
                    @(negedge clk);
                    #1;
                    t++;
                end
                repeat (10) begin
                    check("stall_valid", int'(bus.output_valid), 1);
                    check($sformatf("stall_y%0d", i), int'(bus.output_data), y[i]);
                    @(posedge clk);
                    @(negedge clk);
                end
                t = 0;
            end
            while (!got) begin
                bit rdy;
                rdy = (rnd && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                bus.output_ready = rdy;
                #1;
                if (bus.output_valid && first_v < 0) first_v = cyc;
                if (bus.output_valid && rdy) begin
                    check($sformatf("y%0d", i), int'(bus.output_data), y[i]);
                    got = 1'b1;
                end
                @(posedge clk);
                @(negedge clk);
                t++;
                if (!got && t > 100) begin
                    check($sformatf("output_timeout_y%0d", i), 0, 1);
                    bus.output_ready = 1'b0;
                    return;
                end
            end
        end
        bus.output_ready = 1'b0;
    endtask

    task automatic run_vector(input int stall_at, input bit rnd, output int lat);
        int h, fv;
        compute();
        send_x(h);
        collect(stall_at, rnd, M, fv);
        lat = fv - h;
    endtask

    initial begin
        int lat, h, fv;
        bus.input_valid  = 1'b0;
        bus.input_data   = '0;
        bus.w_valid      = 1'b0;
        bus.w_data       = '0;
        bus.output_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_output_valid", int'(bus.output_valid), 0);
        check("rst_output_data", int'(bus.output_data), 0);
        check("rst_input_ready", int'(bus.input_ready), 1);
        check("rst_w_ready", int'(bus.w_ready), 1);
        reset = 1'b1;
        @(negedge clk);

        // all ones: every output equals N, plus first-output latency
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) W[m][k] = 1;
        for (int k = 0; k < N; k++) xv[k] = 1;
        load_all();
        run_vector(-1, 1'b0, lat);
        check("latency", lat, N + 2);

        // positive and negative saturation
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) W[m][k] = 127;
        load_all();
        for (int k = 0; k < N; k++) xv[k] = 127;
        run_vector(-1, 1'b0, lat);
        for (int k = 0; k < N; k++) xv[k] = -128;
        run_vector(-1, 1'b1, lat);

        // small negative result, ReLU-sensitive
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) W[m][k] = -1;
        load_all();
        for (int k = 0; k < N; k++) xv[k] = 5;
        run_vector(-1, 1'b0, lat);

        // W[m][n]=m-n with a one-hot x, then a stall in the middle of group 1
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) W[m][k] = m - k;
        load_all();
        for (int k = 0; k < N; k++) xv[k] = (k == 3) ? 1 : 0;
        run_vector(6, 1'b0, lat);
        for (int k = 0; k < N; k++) xv[k] = rnd8();
        run_vector(9, 1'b1, lat);

        // 129 weights wrap so the last lands on W[0][0]; input beats w_valid in IDLE
        for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) W[m][k] = rnd8();
        load_all();
        send_w(9);
        W[0][0] = 9;
        for (int k = 0; k < N; k++) xv[k] = rnd8();
        bus.w_valid     = 1'b1;
        bus.w_data      = T'(99);
        bus.input_valid = 1'b1;
        bus.input_data  = T'(xv[0]);
        #1;
        check("w_ready_blocked", int'(bus.w_ready), 0);
        check("input_ready_prio", int'(bus.input_ready), 1);
        compute();
        send_x(h);
        bus.w_valid = 1'b0;
        collect(-1, 1'b1, M, fv);

        // reset during OUT, then same vector again with no weight reload
        send_x(h);
        collect(-1, 1'b0, 2, fv);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", int'(bus.output_valid), 0);
        check("rst_out_data", int'(bus.output_data), 0);
        check("rst_out_idle", int'(bus.input_ready), 1);
        reset = 1'b1;
        @(negedge clk);
        run_vector(-1, 1'b1, lat);

        // fully random weights and inputs
        for (int r = 0; r < 3; r++) begin
            for (int m = 0; m < M; m++) for (int k = 0; k < N; k++) W[m][k] = rnd8();
            load_all();
            for (int v = 0; v < 2; v++) begin
                for (int k = 0; k < N; k++) xv[k] = rnd8();
                run_vector(-1, 1'b1, lat);
                check("rand_latency", lat, N + 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
